// File: rtl/rf_dbg_pkg.sv
// Shared definitions for the register-file debug port: encodings, sizes and
// the response payload record.
package rf_dbg_pkg;

   localparam int NREG = 32;
   localparam int AW   = 5;
   localparam int DW   = 32;

   typedef enum logic [1:0] {
      OP_READ  = 2'b00,
      OP_WRITE = 2'b01,
      OP_DUMP  = 2'b10,
      OP_RSVD  = 2'b11
   } op_e;

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_REQ    = 2'b01,
      S_ACCESS = 2'b10,
      S_RESP   = 2'b11
   } state_e;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          err;
      logic          last;
   } rsp_t;

endpackage

// File: rtl/rf_debug_port_if.sv
// Command and response channels between the debug transport and the
// register-file debug port.
interface rf_debug_port_if;

   logic                       cmd_valid;
   logic                       cmd_ready;
   logic [1:0]                 cmd_op;
   logic [rf_dbg_pkg::AW-1:0]  cmd_addr;
   logic [rf_dbg_pkg::DW-1:0]  cmd_data;

   logic                       rsp_valid;
   logic                       rsp_ready;
   logic [rf_dbg_pkg::AW-1:0]  rsp_addr;
   logic [rf_dbg_pkg::DW-1:0]  rsp_data;
   logic                       rsp_err;
   logic                       rsp_last;

   modport slave (
      input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      output cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_err, rsp_last
   );

   modport master (
      output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_addr, rsp_data, rsp_err, rsp_last
   );

endinterface

// File: rtl/rf_dbg_rsp_hold.sv
// Response payload register: loads a new beat and holds it unchanged while
// the consumer applies backpressure.
module rf_dbg_rsp_hold
   import rf_dbg_pkg::*;
(
   input  logic clk,
   input  logic reset_n,
   input  logic load,
   input  rsp_t din,
   output rsp_t dout
);

   rsp_t hold_r;

   // Capture the payload on load, otherwise keep it stable.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         hold_r <= '0;
      end else if (load) begin
         hold_r <= din;
      end else begin
         hold_r <= hold_r;
      end
   end

   assign dout = hold_r;

endmodule

// File: rtl/rf_debug_port.sv
// Debug access initiator for the 32x32 register file: accepts read, write and
// dump commands, arbitrates for the register-file ports and returns responses.
module rf_debug_port
   import rf_dbg_pkg::*;
(
   input  logic          clk,
   input  logic          reset_n,
   rf_debug_port_if.slave bus,
   output logic          dbg_req,
   input  logic          dbg_grant,
   output logic [AW-1:0] rf_ra,
   input  logic [DW-1:0] rf_rd,
   output logic          rf_we,
   output logic [AW-1:0] rf_wa,
   output logic [DW-1:0] rf_wd
);

   // Counter is one bit wider than the address so the last dump beat is
   // detected without wrapping.
   localparam logic [AW:0] LAST_ADDR = (AW+1)'(NREG - 1);
   localparam logic [AW:0] ADDR_ONE  = {{AW{1'b0}}, 1'b1};

   state_e        state_r, state_s;
   op_e           op_r, op_s;
   logic [AW:0]   addr_r, addr_s;
   logic [DW-1:0] data_r, data_s;
   logic          err_r, err_s;
   logic          load_s;
   rsp_t          rsp_s, rsp_q;

   logic          cmd_ready_r, rsp_valid_r, dbg_req_r, rf_we_r;
   logic [AW-1:0] rf_ra_r, rf_wa_r;
   logic [DW-1:0] rf_wd_r;

   logic accept_s, rsp_fire_s, last_addr_s, acc_nx_s, wr_nx_s;

   assign accept_s    = bus.cmd_valid && cmd_ready_r;
   assign rsp_fire_s  = rsp_valid_r && bus.rsp_ready;
   assign last_addr_s = (addr_r == LAST_ADDR);

   // Next-state, command latching and response payload selection.
   always_comb begin
      state_s = state_r;
      op_s    = op_r;
      addr_s  = addr_r;
      data_s  = data_r;
      err_s   = err_r;
      load_s  = 1'b0;
      rsp_s   = '0;

      rsp_s.addr = addr_r[AW-1:0];
      rsp_s.err  = err_r;
      rsp_s.last = (op_r != OP_DUMP) || err_r || last_addr_s;
      if (err_r) begin
         rsp_s.data = {DW{1'b0}};
      end else if (op_r == OP_WRITE) begin
         rsp_s.data = data_r;
      end else begin
         rsp_s.data = rf_rd;
      end

      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               op_s    = op_e'(bus.cmd_op);
               data_s  = bus.cmd_data;
               state_s = S_REQ;
               if (op_s == OP_DUMP) begin
                  addr_s = {(AW+1){1'b0}};
               end else begin
                  addr_s = {1'b0, bus.cmd_addr};
               end
               // Rejected commands pass through REQ without requesting ports.
               if ((op_s == OP_RSVD) || ((op_s == OP_WRITE) && (bus.cmd_addr == {AW{1'b0}}))) begin
                  err_s = 1'b1;
               end else begin
                  err_s = 1'b0;
               end
            end else begin
               state_s = S_IDLE;
            end
         end
         S_REQ: begin
            if (err_r) begin
               state_s = S_RESP;
               load_s  = 1'b1;
            end else if (dbg_grant) begin
               state_s = S_ACCESS;
            end else begin
               state_s = S_REQ;
            end
         end
         S_ACCESS: begin
            // Losing grant mid-access discards the result and retries.
            if (dbg_grant) begin
               state_s = S_RESP;
               load_s  = 1'b1;
            end else begin
               state_s = S_REQ;
            end
         end
         S_RESP: begin
            if (rsp_fire_s) begin
               if ((op_r == OP_DUMP) && !err_r && !last_addr_s) begin
                  addr_s = addr_r + ADDR_ONE;
                  if (dbg_grant) begin
                     state_s = S_ACCESS;
                  end else begin
                     state_s = S_REQ;
                  end
               end else begin
                  state_s = S_IDLE;
               end
            end else begin
               state_s = S_RESP;
            end
         end
         default: begin
            state_s = S_IDLE;
         end
      endcase
   end

   assign acc_nx_s = (state_s == S_ACCESS);
   assign wr_nx_s  = (op_s == OP_WRITE);

   // State, command registers and registered port drive derived from next state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r     <= S_IDLE;
         op_r        <= OP_READ;
         addr_r      <= {(AW+1){1'b0}};
         data_r      <= {DW{1'b0}};
         err_r       <= 1'b0;
         cmd_ready_r <= 1'b0;
         rsp_valid_r <= 1'b0;
         dbg_req_r   <= 1'b0;
         rf_ra_r     <= {AW{1'b0}};
         rf_we_r     <= 1'b0;
         rf_wa_r     <= {AW{1'b0}};
         rf_wd_r     <= {DW{1'b0}};
      end else begin
         state_r     <= state_s;
         op_r        <= op_s;
         addr_r      <= addr_s;
         data_r      <= data_s;
         err_r       <= err_s;
         cmd_ready_r <= (state_s == S_IDLE);
         rsp_valid_r <= (state_s == S_RESP);
         dbg_req_r   <= (state_s != S_IDLE) && !err_s;
         rf_ra_r     <= (acc_nx_s && !wr_nx_s) ? addr_s[AW-1:0] : {AW{1'b0}};
         rf_we_r     <= acc_nx_s && wr_nx_s;
         rf_wa_r     <= (acc_nx_s && wr_nx_s) ? addr_s[AW-1:0] : {AW{1'b0}};
         rf_wd_r     <= (acc_nx_s && wr_nx_s) ? data_s : {DW{1'b0}};
      end
   end

   rf_dbg_rsp_hold u_rsp_hold (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (load_s),
      .din     (rsp_s),
      .dout    (rsp_q)
   );

   assign bus.cmd_ready = cmd_ready_r;
   assign bus.rsp_valid = rsp_valid_r;
   assign bus.rsp_addr  = rsp_q.addr;
   assign bus.rsp_data  = rsp_q.data;
   assign bus.rsp_err   = rsp_q.err;
   assign bus.rsp_last  = rsp_q.last;
   assign dbg_req       = dbg_req_r;
   assign rf_ra         = rf_ra_r;
   assign rf_we         = rf_we_r;
   assign rf_wa         = rf_wa_r;
   assign rf_wd         = rf_wd_r;

endmodule
